// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the core load/store path and the debug/loader port.
// Core has priority; a starvation counter and a debug lock give the debug port guaranteed progress.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              locked
);

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [0:0] state, state_nxt;
  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == STARVE_LIM);

  // Grants are gated by reset so nothing reaches memory while reset is low.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (state == LOCK) begin
        d_gnt = d_req;
      end else begin
        d_gnt = d_req & (~c_req | starved);
        c_gnt = c_req & ~d_gnt;
      end
    end
  end

  always_comb begin
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else begin
      mem_we    = c_gnt & c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (d_gnt && d_lock) state_nxt = LOCK;
      LOCK:    if (!(d_req && d_lock)) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!d_req || d_gnt)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      d_rvalid <= d_gnt & ~d_we;
      if (c_gnt && !c_we) c_rdata <= mem_rdata;
      if (d_gnt && !d_we) d_rdata <= mem_rdata;
    end
  end

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table with a read-data scoreboard,
// plus hand-written reset sequences, against a behavioural memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we, locked;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwdata;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic        dlock;
    logic        ecg, edg, elk;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [21];
  logic [31:0] c_q [$];
  logic [31:0] d_q [$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked)
  );

  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic creq, input logic cwe, input logic [31:0] caddr,
                              input logic [31:0] cwdata, input logic dreq, input logic dwe,
                              input logic [31:0] daddr, input logic [31:0] dwdata,
                              input logic dlock, input logic ecg, input logic edg,
                              input logic elk, input logic [31:0] erd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
    v.dlock = dlock; v.ecg = ecg; v.edg = edg; v.elk = elk; v.erd = erd;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [31:0] exp_rd;
    logic        exp_rv;
    @(negedge clk);
    reset = 1'b1;
    c_req = v.creq; c_we = v.cwe; c_addr = v.caddr; c_wdata = v.cwdata;
    d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
    d_lock = v.dlock;
    #1;
    chk($sformatf("c_gnt[%0d]", idx), 32'(c_gnt), 32'(v.ecg));
    chk($sformatf("d_gnt[%0d]", idx), 32'(d_gnt), 32'(v.edg));
    chk($sformatf("mem_we[%0d]", idx), 32'(mem_we),
        32'((v.ecg & v.cwe) | (v.edg & v.dwe)));
    chk($sformatf("mem_addr[%0d]", idx), mem_addr, v.edg ? v.daddr : v.caddr);
    chk($sformatf("locked[%0d]", idx), 32'(locked), 32'(v.elk));
    if (v.ecg && !v.cwe) c_q.push_back(v.erd);
    if (v.edg && !v.dwe) d_q.push_back(v.erd);
    @(posedge clk);
    #1;
    exp_rv = (c_q.size() > 0);
    chk($sformatf("c_rvalid[%0d]", idx), 32'(c_rvalid), 32'(exp_rv));
    if (exp_rv) begin
      exp_rd = c_q.pop_front();
      chk($sformatf("c_rdata[%0d]", idx), c_rdata, exp_rd);
    end
    exp_rv = (d_q.size() > 0);
    chk($sformatf("d_rvalid[%0d]", idx), 32'(d_rvalid), 32'(exp_rv));
    if (exp_rv) begin
      exp_rd = d_q.pop_front();
      chk($sformatf("d_rdata[%0d]", idx), d_rdata, exp_rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h8; c_wdata = 32'h12345678;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'h87654321; d_lock = 1'b0;

    //            creq cwe caddr   cwdata        dreq dwe daddr  dwdata        lk  cg dg lk erd
    vecs[0]  = mk(1, 1, 32'h08, 32'hDEADBEEF, 1, 0, 32'h08, 32'h0,        0, 1, 0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h08, 32'h0,        0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h0);
    vecs[3]  = mk(1, 1, 32'h10, 32'hA0000000, 1, 0, 32'h08, 32'h0,        0, 1, 0, 0, 32'h0);
    vecs[4]  = mk(1, 1, 32'h14, 32'hA0000001, 1, 0, 32'h08, 32'h0,        0, 1, 0, 0, 32'h0);
    vecs[5]  = mk(1, 1, 32'h18, 32'hA0000002, 1, 0, 32'h08, 32'h0,        0, 1, 0, 0, 32'h0);
    vecs[6]  = mk(1, 1, 32'h1C, 32'hA0000003, 1, 0, 32'h08, 32'h0,        0, 1, 0, 0, 32'h0);
    vecs[7]  = mk(1, 1, 32'h20, 32'hA0000004, 1, 0, 32'h08, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF);
    vecs[8]  = mk(1, 1, 32'h20, 32'hA0000004, 1, 0, 32'h08, 32'h0,        0, 1, 0, 0, 32'h0);
    vecs[9]  = mk(0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h0);
    vecs[10] = mk(0, 0, 32'h00, 32'h0,        1, 1, 32'h00, 32'h11110000, 1, 0, 1, 0, 32'h0);
    vecs[11] = mk(1, 0, 32'h10, 32'h0,        1, 1, 32'h04, 32'h22220004, 1, 0, 1, 1, 32'h0);
    vecs[12] = mk(1, 0, 32'h10, 32'h0,        1, 1, 32'h08, 32'h33330008, 0, 0, 1, 1, 32'h0);
    vecs[13] = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'hA0000000);
    vecs[14] = mk(1, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'h11110000);
    vecs[15] = mk(1, 0, 32'h04, 32'h0,        0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'h22220004);
    vecs[16] = mk(0, 0, 32'h00, 32'h0,        1, 0, 32'h08, 32'h0,        0, 0, 1, 0, 32'h33330008);
    vecs[17] = mk(0, 0, 32'h00, 32'h0,        1, 1, 32'h30, 32'h55555555, 1, 0, 1, 0, 32'h0);
    vecs[18] = mk(1, 0, 32'h20, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 1, 32'h0);
    vecs[19] = mk(1, 0, 32'h20, 32'h0,        0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'hA0000004);
    vecs[20] = mk(0, 0, 32'h00, 32'h0,        1, 0, 32'h30, 32'h0,        0, 0, 1, 0, 32'h55555555);

    // Reset held low with both sides requesting writes.
    @(negedge clk);
    #1;
    chk("rst_c_gnt", 32'(c_gnt), 32'h0);
    chk("rst_d_gnt", 32'(d_gnt), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_c_rdata", c_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_mem_untouched", mem[2], 32'h0);

    for (int i = 0; i < 21; i++) apply(vecs[i], i);

    // Reset asserted between a core read grant and the capturing edge.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; d_req = 1'b0; d_lock = 1'b0;
    #1;
    chk("midrst_c_gnt", 32'(c_gnt), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_c_gnt_low", 32'(c_gnt), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_c_rvalid", 32'(c_rvalid), 32'h0);
    chk("midrst_c_rdata", c_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    c_req = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_c_rvalid_after", 32'(c_rvalid), 32'h0);
    chk("midrst_c_rdata_after", c_rdata, 32'h0);
    chk("midrst_locked_after", 32'(locked), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the processor's single data memory between the core load/store path and a debug/loader port (memory preload and inspection after a run). Sits between the core's memory-access signals and the data memory's write/read port. At most one access per cycle. The core has priority; a starvation counter guarantees the debug port progress. The debug port can lock the memory for back-to-back bursts.

## Interface
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data word width
- STARVE_MAX, 4, consecutive denied debug-request cycles before debug wins over core (1..15)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write enable (1 = store, 0 = load)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core store data
- c_gnt  out  1  core access performed this cycle (combinational)
- c_rvalid  out  1  core load data valid (registered, 1-cycle pulse)
- c_rdata  out  DATA_W  core load data (registered)
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  debug port request, same meaning as core
- d_lock  in  1  debug requests exclusive ownership after its current grant
- d_gnt, d_rvalid, d_rdata  out  1/1/DATA_W  debug port responses, same meaning as core
- mem_we  out  1  data memory write strobe
- mem_addr  out  ADDR_W  data memory address
- mem_wdata  out  DATA_W  data memory write data
- mem_rdata  in  DATA_W  data memory combinational read data
- locked  out  1  high while in state LOCK (registered)

## Operation
- States: ARB, LOCK. Reset state: ARB.
- Winner selection in ARB:
  - Only one side requests: that side wins.
  - Both sides request: core wins, unless starve_cnt == STARVE_MAX, in which case debug wins.
- Winner selection in LOCK: only debug can be granted. c_gnt = 0 regardless of c_req.
- Grant: the winner's gnt = 1 in the same cycle. The mem_* signals carry the winner's we/addr/wdata.
- mem_we = winner_we & winner_gnt. With no grant, mem_we = 0 and mem_addr/mem_wdata follow the core inputs.
- Read: on a grant with we = 0, mem_rdata is captured into that port's rdata at the clock edge. That port's rvalid is 1 for exactly the next cycle. A write grant produces no rvalid.
- Unread rdata holds its value until the next read on that port.
- starve_cnt (4-bit):
  - Clears when d_req = 0 or on a d_gnt.
  - Increments on each cycle with d_req = 1 and d_gnt = 0.
  - Saturates at STARVE_MAX.
- Transitions:
  - ARB -> LOCK at the edge after a d_gnt with d_lock = 1.
  - LOCK -> ARB at the edge after a d_gnt with d_lock = 0, or any cycle in LOCK with d_req = 0.
  - LOCK stays in LOCK while d_req = 1 & d_lock = 1.
- Requester rule: hold req/we/addr/wdata stable until gnt is seen. Dropping req before grant is legal (request withdrawn, no side effects).

## Timing
- Grant and memory write: combinational, same cycle as request. The write lands at that cycle's rising edge.
- Read latency: rvalid/rdata registered, 1 cycle after grant.
- Throughput: 1 access per cycle in total. Back-to-back grants to the same port are allowed; rvalid then stays high on consecutive cycles with new data each cycle.
- Reset (asserted low, asynchronous, also mid-operation):
  - state = ARB, starve_cnt = 0.
  - c_rvalid = d_rvalid = 0, c_rdata = d_rdata = 0, locked = 0.
  - c_gnt = d_gnt = mem_we = 0 while reset is low.
  - A pending rvalid is discarded. A write in the reset cycle is suppressed.
- Simultaneous events:
  - Debug wins by starvation: core is denied that cycle and keeps its request.
  - A d_lock grant and a core request in the same cycle: the core is already denied by arbitration. Lock takes effect from the next cycle.

## Test plan
- Reset: hold reset = 0 with c_req = d_req = 1 and c_we = 1 -> c_gnt = d_gnt = mem_we = 0, all rvalid = 0, rdata = 0. Release -> core granted in the first cycle.
- Core-only traffic: write 0xDEADBEEF to addr 0x8, then read addr 0x8 -> c_gnt on both cycles. c_rvalid = 1 one cycle after the read grant, with c_rdata = 0xDEADBEEF. d_rvalid stays 0.
- Starvation with STARVE_MAX = 4: c_req and d_req held high continuously -> core granted cycles 0-3, debug granted cycle 4, starve_cnt back to 0, core granted cycle 5.
- Debug lock burst: debug writes addr 0x0, 0x4, 0x8 with d_lock = 1, 1, 0 while c_req = 1 -> once debug is first granted, d_gnt on three consecutive cycles and locked = 1 for the two cycles after the first grant. Core granted the cycle after the last write. Memory holds all three words.
- Lock abort: in LOCK, drop d_req for one cycle -> state returns to ARB at the next edge, locked = 0, and a pending c_req is granted.
- Reset mid-read: core read granted, reset asserted before the next edge -> c_rvalid never pulses and c_rdata = 0 after release.
